vga_tile_scanout: RTL and testbench

- Next-generation VGA scan-out engine for the sale terminal.
- Merges the H/V timing generator and the product-tile pixel path into one parametrised block, driven by the pixel clock from the VGA PLL.
- Generalised over timing, sync polarity, tile-grid geometry and ROM read latency. Adds latency-matched sync/blank outputs, a highlight border and frame-synchronous highlight sampling.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_tile_scanout_if.sv | 33 +++
 rtl/vga_delay_line.sv | 25 ++
 rtl/vga_tile_scanout.sv | 209 ++++++++++++++++++++
 tb/tb_vga_tile_scanout.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants, colour packing and the per-pixel flag bundle used by the
// tile scan-out engine.
package vga_pkg;

    function automatic int timing_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL = timing_total(800, 40, 128, 88);
    localparam int V_TOTAL = timing_total(600, 1, 4, 23);

    function automatic logic [23:0] pack_bgr(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {b, g, r};
    endfunction

    localparam logic [23:0] BG_COLOR_DEF = pack_bgr(8'h20, 8'h20, 8'h20);
    localparam logic [23:0] HL_COLOR_DEF = pack_bgr(8'h00, 8'hFF, 8'h00);

    // Sync flags hold "active" rather than pin level; polarity is applied at the output.
    typedef struct packed {
        logic frame_start;
        logic blank_n;
        logic hs_act;
        logic vs_act;
        logic in_tile;
        logic border;
    } scan_flags_t;

endpackage

// File: rtl/vga_tile_scanout_if.sv
// Pixel-side bundle of the scan-out engine: ROM read port, highlight request
// input and the VGA output pins.
interface vga_tile_scanout_if #(
    parameter int R_WIDTH    = 8,
    parameter int G_WIDTH    = 8,
    parameter int B_WIDTH    = 8,
    parameter int NUM_TILES  = 12,
    parameter int ROM_ADDR_W = 17
);
    logic [NUM_TILES-1:0]               HighlightedProductList;
    logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] PIX_IN;
    logic [ROM_ADDR_W-1:0]              ROM_ADDR;
    logic [R_WIDTH-1:0]                 VGA_R;
    logic [G_WIDTH-1:0]                 VGA_G;
    logic [B_WIDTH-1:0]                 VGA_B;
    logic                               VGA_HS;
    logic                               VGA_VS;
    logic                               VGA_BLANK_N;
    logic                               FRAME_START;
    logic [15:0]                        FRAME_CNT;

    modport master (
        input  HighlightedProductList, PIX_IN,
        output ROM_ADDR, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
               FRAME_START, FRAME_CNT
    );

    modport slave (
        output HighlightedProductList, PIX_IN,
        input  ROM_ADDR, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
               FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen value; keeps
// the pixel flags in step with the ROM read latency.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];
endmodule

// File: rtl/vga_tile_scanout.sv
// VGA timing generator plus product-tile pixel path with a highlight border;
// sync, blank and colour leave the block aligned, ROM_LAT+2 cycles after the counters.
module vga_tile_scanout
    import vga_pkg::*;
#(
    parameter int R_WIDTH       = 8,
    parameter int G_WIDTH       = 8,
    parameter int B_WIDTH       = 8,
    parameter int VISIBLE_H     = 800,
    parameter int FRONT_PORCH_H = 40,
    parameter int SYNC_PULSE_H  = 128,
    parameter int BACK_PORCH_H  = 88,
    parameter int VISIBLE_V     = 600,
    parameter int FRONT_PORCH_V = 1,
    parameter int SYNC_PULSE_V  = 4,
    parameter int BACK_PORCH_V  = 23,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int TILE_W        = 100,
    parameter int TILE_H        = 100,
    parameter int TILE_COLS     = 4,
    parameter int TILE_ROWS     = 3,
    parameter int TILE_X0       = 100,
    parameter int TILE_Y0       = 100,
    parameter int BORDER        = 4,
    parameter int ROM_LAT       = 2,
    parameter int ROM_ADDR_W    = 17,
    parameter logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] BG_COLOR = BG_COLOR_DEF,
    parameter logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] HL_COLOR = HL_COLOR_DEF
) (
    input logic VGA_CLK,
    input logic RST_N,
    vga_tile_scanout_if.master bus
);
    localparam int PIX_W       = R_WIDTH + G_WIDTH + B_WIDTH;
    localparam int NUM_TILES   = TILE_COLS * TILE_ROWS;
    localparam int LINE_LEN    = timing_total(VISIBLE_H, FRONT_PORCH_H, SYNC_PULSE_H, BACK_PORCH_H);
    localparam int FRAME_LINES = timing_total(VISIBLE_V, FRONT_PORCH_V, SYNC_PULSE_V, BACK_PORCH_V);
    localparam int HS_START    = VISIBLE_H + FRONT_PORCH_H;
    localparam int HS_END      = HS_START + SYNC_PULSE_H;
    localparam int VS_START    = VISIBLE_V + FRONT_PORCH_V;
    localparam int VS_END      = VS_START + SYNC_PULSE_V;
    localparam int HW          = $clog2(LINE_LEN);
    localparam int VW          = $clog2(FRAME_LINES);
    localparam int TXW         = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int TYW         = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int CW          = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
    localparam int RW          = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam int IW          = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    if (64'(NUM_TILES) * 64'(TILE_W) * 64'(TILE_H) > (64'd1 << ROM_ADDR_W)) begin : g_addr_chk
        $error("ROM_ADDR_W cannot address every tile image");
    end
    if (TILE_X0 + TILE_COLS * TILE_W > VISIBLE_H ||
        TILE_Y0 + TILE_ROWS * TILE_H > VISIBLE_V) begin : g_grid_chk
        $error("tile grid extends past the visible area");
    end
    if (ROM_LAT < 1) begin : g_lat_chk
        $error("ROM_LAT must be at least 1");
    end

    logic [HW-1:0]        h;
    logic [VW-1:0]        v;
    logic [TXW-1:0]       tx;
    logic [TYW-1:0]       ty;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 in_x, in_y;
    logic [NUM_TILES-1:0] hl_q;
    logic                 h_last, v_last, x_start, y_start;
    logic                 in_tile, on_border;
    logic [IW-1:0]        tile_idx;

    assign h_last    = (32'(h) == LINE_LEN - 1);
    assign v_last    = (32'(v) == FRAME_LINES - 1);
    assign x_start   = (TILE_X0 == 0) ? h_last : (32'(h) == TILE_X0 - 1);
    assign y_start   = (TILE_Y0 == 0) ? v_last : (32'(v) == TILE_Y0 - 1);
    assign in_tile   = in_x && in_y;
    assign tile_idx  = IW'(32'(row) * TILE_COLS + 32'(col));
    assign on_border = (32'(tx) < BORDER) || (32'(tx) >= TILE_W - BORDER) ||
                       (32'(ty) < BORDER) || (32'(ty) >= TILE_H - BORDER);

    // Tile column/offset counters step alongside h and v, so no divider is needed.
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h    <= '0;
            v    <= '0;
            tx   <= '0;
            col  <= '0;
            in_x <= (TILE_X0 == 0);
            ty   <= '0;
            row  <= '0;
            in_y <= (TILE_Y0 == 0);
            hl_q <= '0;
        end else begin
            h <= h_last ? '0 : h + 1'b1;
            if (x_start) begin
                in_x <= 1'b1;
                tx   <= '0;
                col  <= '0;
            end else if (in_x) begin
                if (32'(tx) == TILE_W - 1) begin
                    tx <= '0;
                    if (32'(col) == TILE_COLS - 1) in_x <= 1'b0;
                    else                           col  <= col + 1'b1;
                end else begin
                    tx <= tx + 1'b1;
                end
            end
            if (h_last) begin
                v <= v_last ? '0 : v + 1'b1;
                if (y_start) begin
                    in_y <= 1'b1;
                    ty   <= '0;
                    row  <= '0;
                end else if (in_y) begin
                    if (32'(ty) == TILE_H - 1) begin
                        ty <= '0;
                        if (32'(row) == TILE_ROWS - 1) in_y <= 1'b0;
                        else                           row  <= row + 1'b1;
                    end else begin
                        ty <= ty + 1'b1;
                    end
                end
            end
            // Sampled only on the last counter position so a frame never mixes highlight sets.
            if (h_last && v_last) hl_q <= bus.HighlightedProductList;
        end
    end

    logic [ROM_ADDR_W-1:0] rom_addr;
    scan_flags_t           sa_flags;

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rom_addr <= '0;
            sa_flags <= '0;
        end else begin
            sa_flags.frame_start <= (h == '0) && (v == '0);
            sa_flags.blank_n     <= (32'(h) < VISIBLE_H) && (32'(v) < VISIBLE_V);
            sa_flags.hs_act      <= (32'(h) >= HS_START) && (32'(h) < HS_END);
            sa_flags.vs_act      <= (32'(v) >= VS_START) && (32'(v) < VS_END);
            sa_flags.in_tile     <= in_tile;
            sa_flags.border      <= in_tile && hl_q[tile_idx] && on_border;
            if (in_tile) begin
                rom_addr <= ROM_ADDR_W'(32'(tile_idx) * (TILE_W * TILE_H) +
                                        32'(ty) * TILE_W + 32'(tx));
            end
        end
    end

    assign bus.ROM_ADDR = rom_addr;

    logic [$bits(scan_flags_t)-1:0] dl_out;
    scan_flags_t                    dl_flags;

    vga_delay_line #(
        .WIDTH   ($bits(scan_flags_t)),
        .DEPTH   (ROM_LAT),
        .RST_VAL ('0)
    ) u_flag_delay (
        .clk   (VGA_CLK),
        .rst_n (RST_N),
        .din   (sa_flags),
        .dout  (dl_out)
    );

    assign dl_flags = scan_flags_t'(dl_out);

    logic [PIX_W-1:0] color_next, color_q;
    logic             hs_q, vs_q, blank_n_q, frame_start_q;
    logic [15:0]      frame_cnt;

    always_comb begin
        color_next = '0;
        if (dl_flags.blank_n) begin
            if (!dl_flags.in_tile)    color_next = BG_COLOR;
            else if (dl_flags.border) color_next = HL_COLOR;
            else                      color_next = bus.PIX_IN;
        end
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            color_q       <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            color_q       <= color_next;
            hs_q          <= dl_flags.hs_act ? HS_POL : ~HS_POL;
            vs_q          <= dl_flags.vs_act ? VS_POL : ~VS_POL;
            blank_n_q     <= dl_flags.blank_n;
            frame_start_q <= dl_flags.frame_start;
            frame_cnt     <= frame_cnt + 16'(dl_flags.frame_start);
        end
    end

    assign bus.VGA_R       = color_q[R_WIDTH-1:0];
    assign bus.VGA_G       = color_q[R_WIDTH +: G_WIDTH];
    assign bus.VGA_B       = color_q[R_WIDTH+G_WIDTH +: B_WIDTH];
    assign bus.VGA_HS      = hs_q;
    assign bus.VGA_VS      = vs_q;
    assign bus.VGA_BLANK_N = blank_n_q;
    assign bus.FRAME_START = frame_start_q;
    assign bus.FRAME_CNT   = frame_cnt;
endmodule

// File: tb/tb_vga_tile_scanout.sv
// Scan-out bench on a shrunken timing so many frames fit: a reference model computes
// every output pixel from its (h,v) position; a second instance has inverted sync.
module tb_vga_tile_scanout;
    import vga_pkg::*;

    localparam int VH = 40, FPH = 4, SPH = 8, BPH = 6;
    localparam int VV = 30, FPV = 1, SPV = 2, BPV = 3;
    localparam int HT = VH + FPH + SPH + BPH;
    localparam int VT = VV + FPV + SPV + BPV;
    localparam int FRAME = HT * VT;
    localparam int TW = 8, TH = 6, TC = 3, TR = 2, X0 = 5, Y0 = 4, BRD = 2;
    localparam int LAT = 2, AW = 9, NT = TC * TR, L = LAT + 2;
    localparam logic [23:0] BG = 24'h202020;
    localparam logic [23:0] HL = 24'h00FF00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_tile_scanout_if #(.R_WIDTH(8), .G_WIDTH(8), .B_WIDTH(8), .NUM_TILES(NT), .ROM_ADDR_W(AW)) bus ();
    vga_tile_scanout_if #(.R_WIDTH(8), .G_WIDTH(8), .B_WIDTH(8), .NUM_TILES(NT), .ROM_ADDR_W(AW)) bus_inv ();

    vga_tile_scanout #(
        .VISIBLE_H(VH), .FRONT_PORCH_H(FPH), .SYNC_PULSE_H(SPH), .BACK_PORCH_H(BPH),
        .VISIBLE_V(VV), .FRONT_PORCH_V(FPV), .SYNC_PULSE_V(SPV), .BACK_PORCH_V(BPV),
        .HS_POL(1'b1), .VS_POL(1'b1), .TILE_W(TW), .TILE_H(TH), .TILE_COLS(TC),
        .TILE_ROWS(TR), .TILE_X0(X0), .TILE_Y0(Y0), .BORDER(BRD), .ROM_LAT(LAT),
        .ROM_ADDR_W(AW), .BG_COLOR(BG), .HL_COLOR(HL)
    ) dut (.VGA_CLK(clk), .RST_N(rst_n), .bus(bus));

    vga_tile_scanout #(
        .VISIBLE_H(VH), .FRONT_PORCH_H(FPH), .SYNC_PULSE_H(SPH), .BACK_PORCH_H(BPH),
        .VISIBLE_V(VV), .FRONT_PORCH_V(FPV), .SYNC_PULSE_V(SPV), .BACK_PORCH_V(BPV),
        .HS_POL(1'b0), .VS_POL(1'b0), .TILE_W(TW), .TILE_H(TH), .TILE_COLS(TC),
        .TILE_ROWS(TR), .TILE_X0(X0), .TILE_Y0(Y0), .BORDER(BRD), .ROM_LAT(LAT),
        .ROM_ADDR_W(AW), .BG_COLOR(BG), .HL_COLOR(HL)
    ) dut_inv (.VGA_CLK(clk), .RST_N(rst_n), .bus(bus_inv));

    logic [23:0]    rom_salt;
    logic [23:0]    rom_pipe [LAT];
    logic [NT-1:0]  hl_in, hl_pending, hl_cur;
    logic [AW-1:0]  last_addr;
    int             k, m_cnt, tgt;
    int             errors = 0;
    int             checks = 0;

    function automatic logic [23:0] rom_data(input logic [AW-1:0] a);
        return 24'(a) ^ rom_salt;
    endfunction

    // Image ROM with LAT cycles of read latency.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_data(bus.ROM_ADDR);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.PIX_IN                  = rom_pipe[LAT-1];
    assign bus_inv.PIX_IN              = '0;
    assign bus_inv.HighlightedProductList = '0;

    function automatic bit in_grid(input int h, input int v);
        return h >= X0 && h < X0 + TC * TW && v >= Y0 && v < Y0 + TR * TH;
    endfunction

    function automatic logic [AW-1:0] tile_addr(input int h, input int v);
        int idx;
        idx = ((v - Y0) / TH) * TC + (h - X0) / TW;
        return AW'(idx * TW * TH + ((v - Y0) % TH) * TW + (h - X0) % TW);
    endfunction

    task automatic checkOutput(input string tag, input longint unsigned observed,
                               input longint unsigned expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, k, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_blank"}, bus.VGA_BLANK_N, 0);
        checkOutput({tag, "_rgb"}, {bus.VGA_B, bus.VGA_G, bus.VGA_R}, 0);
        checkOutput({tag, "_hs"}, bus.VGA_HS, 0);
        checkOutput({tag, "_vs"}, bus.VGA_VS, 0);
        checkOutput({tag, "_hs_inv"}, bus_inv.VGA_HS, 1);
        checkOutput({tag, "_vs_inv"}, bus_inv.VGA_VS, 1);
        checkOutput({tag, "_fs"}, bus.FRAME_START, 0);
        checkOutput({tag, "_cnt"}, bus.FRAME_CNT, 0);
        checkOutput({tag, "_addr"}, bus.ROM_ADDR, 0);
    endtask

    task automatic restartModel();
        k = 0;
        m_cnt = 0;
        hl_pending = '0;
        hl_cur = '0;
        last_addr = '0;
    endtask

    // Output after edge k shows pixel position k-L; ROM_ADDR shows position k-1.
    task automatic checkCycle();
        int p, h, v, tx, ty, idx;
        bit exp_blank, exp_hs, exp_vs, exp_fs;
        logic [23:0] exp_rgb;
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (in_grid(h, v)) last_addr = tile_addr(h, v);
        checkOutput("rom_addr", bus.ROM_ADDR, last_addr);

        p = k - L;
        exp_blank = 0; exp_hs = 0; exp_vs = 0; exp_fs = 0; exp_rgb = '0;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            if (p % FRAME == 0) begin
                exp_fs = 1;
                m_cnt  = (m_cnt + 1) & 16'hFFFF;
                hl_cur = hl_pending;
            end
            exp_blank = (h < VH) && (v < VV);
            exp_hs    = (h >= VH + FPH) && (h < VH + FPH + SPH);
            exp_vs    = (v >= VV + FPV) && (v < VV + FPV + SPV);
            if (exp_blank) begin
                if (!in_grid(h, v)) exp_rgb = BG;
                else begin
                    tx  = (h - X0) % TW;
                    ty  = (v - Y0) % TH;
                    idx = ((v - Y0) / TH) * TC + (h - X0) / TW;
                    if (hl_cur[idx] && (tx < BRD || tx >= TW - BRD || ty < BRD || ty >= TH - BRD))
                        exp_rgb = HL;
                    else
                        exp_rgb = rom_data(tile_addr(h, v));
                end
            end
        end
        checkOutput("blank_n", bus.VGA_BLANK_N, exp_blank);
        checkOutput("hs", bus.VGA_HS, exp_hs);
        checkOutput("vs", bus.VGA_VS, exp_vs);
        checkOutput("hs_inv", bus_inv.VGA_HS, !exp_hs);
        checkOutput("vs_inv", bus_inv.VGA_VS, !exp_vs);
        checkOutput("rgb", {bus.VGA_B, bus.VGA_G, bus.VGA_R}, exp_rgb);
        checkOutput("frame_start", bus.FRAME_START, exp_fs);
        checkOutput("frame_cnt", bus.FRAME_CNT, m_cnt);
    endtask

    // Drives the highlight list for cycle k and records what the frame-end sample will see.
    task automatic applyStimulus();
        if (k == 15 * HT + 20) hl_in = NT'(1);
        else if (k > 2 * FRAME && $urandom_range(0, 399) == 0) hl_in = NT'($urandom);
        bus.HighlightedProductList = hl_in;
        if (k % FRAME == FRAME - 1) hl_pending = hl_in;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
            checkCycle();
            applyStimulus();
        end
    endtask

    initial begin
        rom_salt = 24'($urandom);
        hl_in = '0;
        bus.HighlightedProductList = '0;
        restartModel();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("por");
        rst_n = 1'b1;
        restartModel();
        applyStimulus();
        runCycles(5 * FRAME);

        tgt = $urandom_range(5, 25) * HT + $urandom_range(10, 30);
        runCycles((tgt - k % FRAME + FRAME) % FRAME);
        #1 rst_n = 1'b0;
        #1 checkResetState("async");
        repeat (3) @(negedge clk);
        checkResetState("held");
        rst_n = 1'b1;
        hl_in = NT'($urandom);
        restartModel();
        applyStimulus();
        runCycles(FRAME + 500);

        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        runCycles(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
